// File: rtl/lpc_io_responder.sv
// ============================================================================
// Module   : lpc_io_responder
// Purpose  : LPC I/O target response stage. It holds the register bank and
//            drives the SYNC, data and turn-around nibbles onto LAD.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lpc_io_responder #(
    parameter int          NUM_REGS    = 32,
    parameter int          WAIT_STATES = 0,
    parameter logic [7:0]  BOARD_ID    = 8'hA5
) (
    input  logic                    LpcClock,
    input  logic                    PciReset,
    input  logic                    LpcFrame,
    input  logic                    AddrValid,
    input  logic                    Opcode,
    input  logic [7:0]              AddrReg,
    input  logic                    Wr,
    input  logic [7:0]              DataWr,
    output logic [3:0]              LpcDataOut,
    output logic                    LpcOe,
    output logic                    Busy,
    output logic [8*NUM_REGS-1:0]   RegFile
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_HTAR = 4'd1,
        S_WDAT = 4'd2,
        S_WAIT = 4'd3,
        S_SYNC = 4'd4,
        S_DLO  = 4'd5,
        S_DHI  = 4'd6,
        S_PTAR = 4'd7,
        S_REL  = 4'd8
    } state_t;

    localparam logic [3:0] c_SYNC_WAIT  = 4'b0101;
    localparam logic [3:0] c_SYNC_READY = 4'b0000;
    localparam logic [3:0] c_LAD_IDLE   = 4'hF;
    localparam logic [3:0] c_WAIT_LAST  = 4'(WAIT_STATES - 1);

    state_t       r_state;
    logic [3:0]   r_cnt;
    logic         r_op;
    logic [4:0]   r_addr;
    logic [7:0]   r_data;
    logic         r_wr_done;
    logic [7:0]   w_rd_data;
    logic         w_wr_accept;
    logic [7:0]   w_regs [32];
    logic         w_unused;

    assign w_unused = ^AddrReg[7:5];

    // One write per bus cycle, only while the host/target still owns the write handshake.
    assign w_wr_accept = Wr && LpcFrame && r_op && !r_wr_done &&
                         ((r_state == S_WDAT) || (r_state == S_HTAR) ||
                          (r_state == S_WAIT) || (r_state == S_SYNC));

    assign w_rd_data = w_regs[r_addr];

    always_ff @(posedge LpcClock or posedge PciReset) begin
        if (PciReset) begin
            r_wr_done <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_wr_done <= 1'b0;
        end else if (w_wr_accept) begin
            r_wr_done <= 1'b1;
        end
    end

    // Register 0 is the board ID; slots past NUM_REGS read as all ones.
    generate
        for (genvar i = 0; i < 32; i++) begin : g_slot
            if (i == 0) begin : g_id
                assign w_regs[i] = BOARD_ID;
            end else if (i < NUM_REGS) begin : g_store
                logic [7:0] r_q;
                always_ff @(posedge LpcClock or posedge PciReset) begin
                    if (PciReset) begin
                        r_q <= 8'h00;
                    end else if (w_wr_accept && (r_addr == 5'(i))) begin
                        r_q <= DataWr;
                    end
                end
                assign w_regs[i] = r_q;
            end else begin : g_absent
                assign w_regs[i] = 8'hFF;
            end
        end
        for (genvar j = 0; j < NUM_REGS; j++) begin : g_flat
            assign RegFile[8*j +: 8] = w_regs[j];
        end
    endgenerate

    always_ff @(posedge LpcClock or posedge PciReset) begin
        if (PciReset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_op       <= 1'b0;
            r_addr     <= 5'd0;
            r_data     <= 8'h00;
            LpcOe      <= 1'b0;
            LpcDataOut <= c_LAD_IDLE;
            Busy       <= 1'b0;
        end else if ((r_state != S_IDLE) && !LpcFrame) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            LpcOe      <= 1'b0;
            LpcDataOut <= c_LAD_IDLE;
            Busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (AddrValid) begin
                        r_op    <= Opcode;
                        r_addr  <= AddrReg[4:0];
                        r_cnt   <= 4'd0;
                        Busy    <= 1'b1;
                        r_state <= Opcode ? S_WDAT : S_HTAR;
                    end
                    LpcOe      <= 1'b0;
                    LpcDataOut <= c_LAD_IDLE;
                end
                S_WDAT: begin
                    if (r_cnt == 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_state <= S_HTAR;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_HTAR: begin
                    if (r_cnt == 4'd1) begin
                        r_cnt <= 4'd0;
                        LpcOe <= 1'b1;
                        if (WAIT_STATES > 0) begin
                            r_state    <= S_WAIT;
                            LpcDataOut <= c_SYNC_WAIT;
                        end else begin
                            r_state    <= S_SYNC;
                            LpcDataOut <= c_SYNC_READY;
                            r_data     <= w_rd_data;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == c_WAIT_LAST) begin
                        r_cnt      <= 4'd0;
                        r_state    <= S_SYNC;
                        LpcDataOut <= c_SYNC_READY;
                        r_data     <= w_rd_data;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_SYNC: begin
                    if (r_op) begin
                        r_state    <= S_PTAR;
                        LpcDataOut <= c_LAD_IDLE;
                    end else begin
                        r_state    <= S_DLO;
                        LpcDataOut <= r_data[3:0];
                    end
                end
                S_DLO: begin
                    r_state    <= S_DHI;
                    LpcDataOut <= r_data[7:4];
                end
                S_DHI: begin
                    r_state    <= S_PTAR;
                    LpcDataOut <= c_LAD_IDLE;
                end
                S_PTAR: begin
                    r_state    <= S_REL;
                    LpcOe      <= 1'b0;
                    LpcDataOut <= c_LAD_IDLE;
                end
                S_REL: begin
                    r_state <= S_IDLE;
                    Busy    <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    LpcOe      <= 1'b0;
                    LpcDataOut <= c_LAD_IDLE;
                    Busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lpc_io_responder.sv
// ============================================================================
// Module   : tb_lpc_io_responder
// Purpose  : Scoreboard bench for lpc_io_responder with zero and three wait states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lpc_io_responder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         frame = 1'b1;
    logic         addr_valid = 1'b0;
    logic         opcode = 1'b0;
    logic [7:0]   addr = 8'h00;
    logic         wr = 1'b0;
    logic [7:0]   data_wr = 8'h00;

    logic [3:0]   dout0, dout3;
    logic         oe0, oe3, busy0, busy3;
    logic [255:0] regs0, regs3;

    int           n_chk = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           q0[$];
    int           q3[$];
    logic [7:0]   m_regs [32];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lpc_io_responder #(.NUM_REGS(32), .WAIT_STATES(0), .BOARD_ID(8'hA5)) u_dut0 (
        .LpcClock(clk), .PciReset(rst), .LpcFrame(frame), .AddrValid(addr_valid),
        .Opcode(opcode), .AddrReg(addr), .Wr(wr), .DataWr(data_wr),
        .LpcDataOut(dout0), .LpcOe(oe0), .Busy(busy0), .RegFile(regs0)
    );

    lpc_io_responder #(.NUM_REGS(32), .WAIT_STATES(3), .BOARD_ID(8'hA5)) u_dut3 (
        .LpcClock(clk), .PciReset(rst), .LpcFrame(frame), .AddrValid(addr_valid),
        .Opcode(opcode), .AddrReg(addr), .Wr(wr), .DataWr(data_wr),
        .LpcDataOut(dout3), .LpcOe(oe3), .Busy(busy3), .RegFile(regs3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Each scoreboard entry packs the expected cycle number and LAD nibble.
    always @(negedge clk) begin
        if (oe0) begin
            if (q0.size() == 0) chk("lad0_spurious", {28'd0, dout0}, 32'hDEAD);
            else chk("lad0", cyc * 16 + int'(dout0), q0.pop_front());
        end
        if (oe3) begin
            if (q3.size() == 0) chk("lad3_spurious", {28'd0, dout3}, 32'hDEAD);
            else chk("lad3", cyc * 16 + int'(dout3), q3.pop_front());
        end
    end

    task automatic push1(input int w, input int t, input logic [3:0] nib, input int lim);
        if (t < lim) begin
            if (w == 0) q0.push_back(t * 16 + int'(nib));
            else        q3.push_back(t * 16 + int'(nib));
        end
    endtask

    task automatic push_txn(input int a, input bit is_wr, input logic [7:0] d, input int cut);
        int t;
        for (int w = 0; w <= 3; w += 3) begin
            t = a + (is_wr ? 4 : 2);
            for (int k = 0; k < w; k++) begin
                push1(w, t, 4'h5, a + cut);
                t++;
            end
            push1(w, t, 4'h0, a + cut);
            t++;
            if (!is_wr) begin
                push1(w, t, d[3:0], a + cut);
                t++;
                push1(w, t, d[7:4], a + cut);
                t++;
            end
            push1(w, t, 4'hF, a + cut);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic start(input bit op, input logic [7:0] ad, output int a);
        addr_valid = 1'b1;
        opcode     = op;
        addr       = ad;
        step();
        addr_valid = 1'b0;
        a          = cyc;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 32; i++) begin
            chk({tag, "_r0"}, {24'd0, regs0[8*i +: 8]}, {24'd0, m_regs[i]});
            chk({tag, "_r3"}, {24'd0, regs3[8*i +: 8]}, {24'd0, m_regs[i]});
        end
    endtask

    task automatic do_read(input logic [7:0] ad, input bit noise);
        int a;
        start(1'b0, ad, a);
        push_txn(a, 1'b0, m_regs[ad[4:0]], 99);
        chk("busy0_start", {31'd0, busy0}, 32'd1);
        chk("busy3_start", {31'd0, busy3}, 32'd1);
        if (noise) begin
            // Stray Wr and AddrValid while a read is in flight must change nothing.
            step();
            wr = 1'b1; data_wr = 8'hEE; addr_valid = 1'b1; addr = 8'h07;
            step();
            wr = 1'b0; addr_valid = 1'b0;
        end
        wait_until(a + 12);
        chk("busy0_end", {31'd0, busy0}, 32'd0);
        chk("busy3_end", {31'd0, busy3}, 32'd0);
    endtask

    task automatic do_write(input logic [7:0] ad, input logic [7:0] d, input int wr_at,
                            input bit dbl, input logic [7:0] d2);
        int a;
        start(1'b1, ad, a);
        push_txn(a, 1'b1, 8'h00, 99);
        repeat (wr_at) step();
        wr = 1'b1; data_wr = d;
        step();
        wr = 1'b0;
        if (dbl) begin
            step();
            wr = 1'b1; data_wr = d2;
            step();
            wr = 1'b0;
        end
        if (ad[4:0] != 5'd0) m_regs[ad[4:0]] = d;
        wait_until(a + 12);
    endtask

    task automatic model_reset();
        m_regs[0] = 8'hA5;
        for (int i = 1; i < 32; i++) m_regs[i] = 8'h00;
    endtask

    initial begin
        int a;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_oe0", {31'd0, oe0}, 32'd0);
        chk("rst_oe3", {31'd0, oe3}, 32'd0);
        chk("rst_dout0", {28'd0, dout0}, 32'hF);
        chk("rst_busy0", {31'd0, busy0}, 32'd0);
        check_regs("rst");
        rst = 1'b0;
        step();

        do_read(8'h00, 1'b0);
        do_write(8'h05, 8'h3C, 2, 1'b0, 8'h00);
        chk("reg5_0", {24'd0, regs0[47:40]}, 32'h3C);
        do_read(8'h05, 1'b0);
        do_write(8'h00, 8'h77, 2, 1'b0, 8'h00);
        do_read(8'h00, 1'b0);
        do_write(8'h06, 8'h11, 0, 1'b1, 8'h22);
        check_regs("dblwr");

        wr = 1'b1; data_wr = 8'h99;
        step();
        wr = 1'b0;
        step();
        check_regs("idlewr");
        do_read(8'h06, 1'b1);
        check_regs("readwr");

        // Abort during DLO of the zero-wait instance.
        start(1'b0, 8'h05, a);
        push_txn(a, 1'b0, m_regs[5], 4);
        step();
        addr_valid = 1'b1;
        step();
        addr_valid = 1'b0;
        step();
        frame = 1'b0; addr_valid = 1'b1;
        step();
        frame = 1'b1; addr_valid = 1'b0;
        chk("abort_busy0", {31'd0, busy0}, 32'd0);
        chk("abort_busy3", {31'd0, busy3}, 32'd0);
        chk("abort_oe0", {31'd0, oe0}, 32'd0);
        chk("abort_oe3", {31'd0, oe3}, 32'd0);
        wait_until(a + 6);
        do_read(8'h05, 1'b0);

        // Asynchronous reset in the middle of PTAR.
        start(1'b0, 8'h05, a);
        push_txn(a, 1'b0, m_regs[5], 5);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_oe0", {31'd0, oe0}, 32'd0);
        chk("arst_oe3", {31'd0, oe3}, 32'd0);
        chk("arst_dout0", {28'd0, dout0}, 32'hF);
        chk("arst_busy0", {31'd0, busy0}, 32'd0);
        model_reset();
        check_regs("arst");
        step();
        rst = 1'b0;
        step();
        do_read(8'h05, 1'b0);

        chk("q0_left", q0.size(), 32'd0);
        chk("q3_left", q3.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
